debug_frame_tx: RTL and testbench
=================================

# debug_frame_tx

Debug snapshot serializer for the MIPS debug path: captures PC, instruction and a debug data word on a start pulse and streams them as a framed byte sequence into the UART transmitter through the `tx_start`/`tx_done_tick` handshake. It is the transmit-direction counterpart of the byte-to-instruction assembler on the receive side: that block packs UART bytes into 32-bit words, this one unpacks 32-bit words into UART bytes. It sits between `top_mips` debug outputs and `uart_tx`.

## Interface

Parameters:
- `NB_DATA`, 32, width of each captured word (must be a multiple of 8)
- `NB_BYTE`, 8, UART data width
- `HEADER`, 8'hA5, frame start byte

Ports (one clock; reset is synchronous and active-low):
- `i_clk`  in  1  system clock
- `i_reset`  in  1  synchronous, active-low reset
- `i_start`  in  1  one-cycle request to capture and send a frame
- `i_pc`  in  NB_DATA  program counter to report
- `i_instruction`  in  NB_DATA  instruction to report
- `i_data`  in  NB_DATA  debug data word to report
- `i_tx_done_tick`  in  1  byte-complete pulse from `uart_tx`
- `o_tx_start`  out  1  one-cycle pulse, start transmitting `o_tx_data`
- `o_tx_data`  out  NB_BYTE  byte presented to `uart_tx`
- `o_busy`  out  1  frame in progress
- `o_done`  out  1  one-cycle pulse after the last byte completes

## Operation

- Frame order: `HEADER`, `i_pc`, `i_instruction`, `i_data`; each word is sent MSB byte first. Frame length is 1 + 3·NB_DATA/8 bytes (13 at defaults), plus 1 with the checksum option.
- Words are latched on the `i_start` cycle; input changes during a frame are ignored.
- FSM states:
  - IDLE: `o_busy`=0. Goes to LOAD on `i_start`.
  - LOAD: drives the current byte on `o_tx_data` and pulses `o_tx_start`, then goes to WAIT.
  - WAIT: holds `o_tx_data` stable. On `i_tx_done_tick`, increments the byte index; goes to LOAD if bytes remain, otherwise to DONE.
  - DONE: pulses `o_done` and returns to IDLE.
- Byte index counter is ceil(log2(frame length)) bits wide and clears in IDLE.
- `i_start` while `o_busy`=1 is ignored and not queued.
- `i_tx_done_tick` outside WAIT is ignored.
- Reset values: `o_tx_start`=0, `o_tx_data`=8'h00, `o_busy`=0, `o_done`=0, state IDLE, index 0, latched words 0.
- Reset asserted mid-frame aborts the frame at the next edge. No `o_done` is issued.

## Timing

- Cycle 0: `i_start`=1 sampled. Cycle 1: LOAD, with `o_tx_start`=1, `o_tx_data`=HEADER and `o_busy`=1.
- Each later byte: `i_tx_done_tick` in cycle n puts `o_tx_start` high in cycle n+1 with the new byte.
- `o_tx_data` changes only in LOAD cycles.
- After the final `i_tx_done_tick` in cycle n, `o_done`=1 in cycle n+1 and `o_busy`=0 in cycle n+2.
- A new `i_start` is accepted from cycle n+2.
- `o_busy` is high from LOAD of the header through DONE inclusive.

## Configuration

- `DEBUG_FRAME_CHECKSUM_EN` defined: one extra trailing byte is sent, the XOR of all preceding bytes including HEADER. Frame is 14 bytes at defaults.
- Not defined: no checksum byte. Frame is 13 bytes at defaults. The XOR accumulator logic is not compiled.

## Test plan

- Reset then idle: hold `i_reset`=0 for 3 cycles → all outputs 0, and `o_tx_start` never pulses without `i_start`.
- Single frame: pc=32'h00000004, instr=32'h8C220000, data=32'hDEADBEEF, with done ticks 10 cycles after each start → byte stream A5 00 00 00 04 8C 22 00 00 DE AD BE EF, then `o_done` one cycle after the 13th tick.
- Checksum build: same stimulus with `DEBUG_FRAME_CHECKSUM_EN` defined → 14th byte equals the XOR of the 13 bytes (computed in the bench), and `o_done` follows the 14th tick.
- Busy rejection: `i_start` pulsed at byte 5 with different inputs → frame content unchanged and no second frame after `o_done`.
- Stray ticks: `i_tx_done_tick` pulsed in IDLE and in a LOAD cycle → no index advance and stream identical to the single-frame case.
- Reset mid-frame: `i_reset`=0 during byte 7 WAIT → next cycle `o_busy`=0 and no `o_done`; a fresh `i_start` then sends a full frame starting with A5.

Source files
------------

// File: rtl/debug_frame_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : debug_frame_tx_if
// Description : Handshake bundle between the debug snapshot source, the
//               debug frame serializer and the UART transmitter.
//               slave  = serializer side, master = driver/environment side.
// Revision    : 1.0 - initial release
// ============================================================================
interface debug_frame_tx_if #(
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = 8
);
    logic               i_start;
    logic [NB_DATA-1:0] i_pc;
    logic [NB_DATA-1:0] i_instruction;
    logic [NB_DATA-1:0] i_data;
    logic               i_tx_done_tick;
    logic               o_tx_start;
    logic [NB_BYTE-1:0] o_tx_data;
    logic               o_busy;
    logic               o_done;

    modport master (
        output i_start,
        output i_pc,
        output i_instruction,
        output i_data,
        output i_tx_done_tick,
        input  o_tx_start,
        input  o_tx_data,
        input  o_busy,
        input  o_done
    );

    modport slave (
        input  i_start,
        input  i_pc,
        input  i_instruction,
        input  i_data,
        input  i_tx_done_tick,
        output o_tx_start,
        output o_tx_data,
        output o_busy,
        output o_done
    );
endinterface
`default_nettype wire

// File: rtl/debug_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : debug_frame_tx
// Description : Captures PC, instruction and a debug data word on a start
//               pulse and streams HEADER, PC, INSTR, DATA (MSB byte first)
//               into a UART transmitter via the tx_start/tx_done_tick
//               handshake.
//               Optional feature macro: DEBUG_FRAME_CHECKSUM_EN - appends one
//               trailing byte, the XOR of all preceding bytes incl. HEADER.
// Revision    : 1.0 - initial release
// ============================================================================
module debug_frame_tx #(
    parameter int                 NB_DATA = 32,
    parameter int                 NB_BYTE = 8,
    parameter logic [NB_BYTE-1:0] HEADER  = 8'hA5
) (
    input  wire logic          i_clk,
    input  wire logic          i_reset,   // synchronous, active-low
    debug_frame_tx_if.slave    bus
);

    localparam int WORD_BYTES = NB_DATA / NB_BYTE;
    localparam int DATA_BYTES = 1 + 3 * WORD_BYTES;   // header + three words
`ifdef DEBUG_FRAME_CHECKSUM_EN
    localparam int FRAME_LEN  = DATA_BYTES + 1;
`else
    localparam int FRAME_LEN  = DATA_BYTES;
`endif
    localparam int IDX_W      = $clog2(FRAME_LEN);
    localparam int FRAME_BITS = NB_BYTE + 3 * NB_DATA;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NB_DATA-1:0] pc_q, pc_d;
    logic [NB_DATA-1:0] instr_q, instr_d;
    logic [NB_DATA-1:0] data_q, data_d;
    logic [NB_BYTE-1:0] tx_data_q, tx_data_d;
`ifdef DEBUG_FRAME_CHECKSUM_EN
    logic [NB_BYTE-1:0] chk_q, chk_d;
`endif

    logic [IDX_W-1:0]      next_idx;
    logic [IDX_W-1:0]      sel_idx;
    logic                  last_byte;
    logic [FRAME_BITS-1:0] frame_bits;
    logic [NB_BYTE-1:0]    byte_sel;

    // Index arithmetic: which byte is loaded on the next LOAD entry
    always_comb begin
        next_idx  = idx_q + IDX_W'(1);
        last_byte = (idx_q == IDX_W'(FRAME_LEN - 1));
        // From IDLE the header (index 0) is next; otherwise the following byte
        sel_idx   = (state_q == S_IDLE) ? '0 : next_idx;
    end

    // Byte mux over the latched frame; header is a constant so it is valid
    // even before the words are latched on the start cycle
    always_comb begin
        frame_bits = {HEADER, pc_q, instr_q, data_q};
        byte_sel   = '0;
        for (int k = 0; k < DATA_BYTES; k++) begin
            if (sel_idx == IDX_W'(k)) begin
                byte_sel = frame_bits[FRAME_BITS-1-k*NB_BYTE -: NB_BYTE];
            end
        end
`ifdef DEBUG_FRAME_CHECKSUM_EN
        if (sel_idx == IDX_W'(DATA_BYTES)) begin
            byte_sel = chk_q;
        end
`endif
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            pc_q      <= '0;
            instr_q   <= '0;
            data_q    <= '0;
            tx_data_q <= '0;
`ifdef DEBUG_FRAME_CHECKSUM_EN
            chk_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            data_q    <= data_d;
            tx_data_q <= tx_data_d;
`ifdef DEBUG_FRAME_CHECKSUM_EN
            chk_q     <= chk_d;
`endif
        end
    end

    // Next-state logic: IDLE -> LOAD -> WAIT -> (LOAD | DONE) -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.i_tx_done_tick) begin
                    state_d = last_byte ? S_DONE : S_LOAD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output and datapath updates; tx_data is loaded on LOAD entry so it
    // only changes at the start of a LOAD cycle and is stable through WAIT
    always_comb begin
        idx_d     = idx_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        data_d    = data_q;
        tx_data_d = tx_data_q;
`ifdef DEBUG_FRAME_CHECKSUM_EN
        chk_d     = chk_q;
`endif
        case (state_q)
            S_IDLE: begin
                idx_d = '0;
`ifdef DEBUG_FRAME_CHECKSUM_EN
                chk_d = '0;
`endif
                if (bus.i_start) begin
                    pc_d      = bus.i_pc;
                    instr_d   = bus.i_instruction;
                    data_d    = bus.i_data;
                    tx_data_d = byte_sel;
`ifdef DEBUG_FRAME_CHECKSUM_EN
                    chk_d     = byte_sel;
`endif
                end
            end
            S_WAIT: begin
                if (bus.i_tx_done_tick && !last_byte) begin
                    idx_d     = next_idx;
                    tx_data_d = byte_sel;
`ifdef DEBUG_FRAME_CHECKSUM_EN
                    chk_d     = chk_q ^ byte_sel;
`endif
                end
            end
            default: begin
            end
        endcase
    end

    // Port drive
    always_comb begin
        bus.o_tx_start = (state_q == S_LOAD);
        bus.o_tx_data  = tx_data_q;
        bus.o_busy     = (state_q != S_IDLE);
        bus.o_done     = (state_q == S_DONE);
    end

endmodule
`default_nettype wire

// File: tb/tb_debug_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_debug_frame_tx
// Description : Self-checking bench for debug_frame_tx. Expected bytes are
//               queued when a frame is requested and popped by a monitor on
//               every tx_start pulse; a UART model answers with done ticks.
//               Honours DEBUG_FRAME_CHECKSUM_EN for the trailing XOR byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_frame_tx;

    logic clk;
    logic rst_n;

    debug_frame_tx_if #(.NB_DATA(32), .NB_BYTE(8)) bus ();

    debug_frame_tx #(
        .NB_DATA (32),
        .NB_BYTE (8),
        .HEADER  (8'hA5)
    ) u_dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] sb_q[$];
    int         exp_done = 0;

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Monitor: every tx_start must match the next queued byte, every done
    // must correspond to an outstanding frame
    always @(negedge clk) begin
        if (bus.o_tx_start) begin
            if (sb_q.size() == 0) begin
                chk_val("tx_start_expected", 32'(sb_q.size() != 0), 32'd1);
            end else begin
                chk_val("tx_byte", {24'd0, bus.o_tx_data}, {24'd0, sb_q.pop_front()});
            end
        end
        if (bus.o_done) begin
            chk_val("done_expected", 32'(exp_done > 0), 32'd1);
            if (exp_done > 0) exp_done--;
        end
    end

    // Request one frame and act as the UART for it
    task automatic send_frame(input logic [31:0] pc, input logic [31:0] ins,
                              input logic [31:0] dat, input int reject_at,
                              input bit stray_load, input int abort_at);
        logic [7:0]  stream[$];
        logic [31:0] words[3];
        logic [7:0]  x;
        int          cnt;
        words = '{pc, ins, dat};
        stream.push_back(8'hA5);
        for (int w = 0; w < 3; w++)
            for (int b = 0; b < 4; b++)
                stream.push_back(words[w][31-8*b -: 8]);
`ifdef DEBUG_FRAME_CHECKSUM_EN
        x = 8'h00;
        foreach (stream[i]) x = x ^ stream[i];
        stream.push_back(x);
`else
        x = 8'h00;
`endif
        foreach (stream[i]) sb_q.push_back(stream[i]);
        exp_done++;

        bus.i_start       = 1'b1;
        bus.i_pc          = pc;
        bus.i_instruction = ins;
        bus.i_data        = dat;
        @(negedge clk);
        bus.i_start       = 1'b0;
        bus.i_pc          = ~pc;
        bus.i_instruction = ~ins;
        bus.i_data        = ~dat;
        chk_val("start_latency", {31'd0, bus.o_tx_start}, 32'd1);
        chk_val("busy_at_load", {31'd0, bus.o_busy}, 32'd1);

        for (int k = 0; k < stream.size(); k++) begin
            cnt = 0;
            while (!bus.o_tx_start && cnt < 40) begin
                @(negedge clk);
                cnt++;
            end
            if (!bus.o_tx_start) begin
                chk_val("tx_start_timeout", {31'd0, bus.o_tx_start}, 32'd1);
                sb_q.delete();
                exp_done = 0;
                return;
            end
            if (k == abort_at) begin
                repeat (3) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                chk_val("abort_busy", {31'd0, bus.o_busy}, 32'd0);
                chk_val("abort_done", {31'd0, bus.o_done}, 32'd0);
                rst_n = 1'b1;
                sb_q.delete();
                exp_done = 0;
                repeat (20) @(negedge clk);
                chk_val("abort_idle", {31'd0, bus.o_busy}, 32'd0);
                return;
            end
            // a tick here lands in the LOAD cycle and must be ignored
            bus.i_tx_done_tick = (stray_load && k == 0);
            @(negedge clk);
            bus.i_tx_done_tick = 1'b0;
            if (k == reject_at) begin
                bus.i_start       = 1'b1;
                bus.i_pc          = 32'h1111_1111;
                bus.i_instruction = 32'h2222_2222;
                bus.i_data        = 32'h3333_3333;
                @(negedge clk);
                bus.i_start       = 1'b0;
            end else begin
                @(negedge clk);
            end
            repeat (8) @(negedge clk);
            chk_val("hold_tx_data", {24'd0, bus.o_tx_data}, {24'd0, stream[k]});
            chk_val("busy_in_frame", {31'd0, bus.o_busy}, 32'd1);
            bus.i_tx_done_tick = 1'b1;
            @(negedge clk);
            bus.i_tx_done_tick = 1'b0;
        end
        chk_val("done_pulse", {31'd0, bus.o_done}, 32'd1);
        chk_val("busy_at_done", {31'd0, bus.o_busy}, 32'd1);
        @(negedge clk);
        chk_val("busy_after_done", {31'd0, bus.o_busy}, 32'd0);
        chk_val("done_cleared", {31'd0, bus.o_done}, 32'd0);
        chk_val("sb_drained", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk_val("idle_tx_start", {31'd0, bus.o_tx_start}, 32'd0);
        end
        chk_val("idle_busy", {31'd0, bus.o_busy}, 32'd0);
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.i_start        = 1'b0;
        bus.i_pc           = 32'h0;
        bus.i_instruction  = 32'h0;
        bus.i_data         = 32'h0;
        bus.i_tx_done_tick = 1'b0;
        repeat (3) @(negedge clk);
        chk_val("rst_tx_start", {31'd0, bus.o_tx_start}, 32'd0);
        chk_val("rst_tx_data", {24'd0, bus.o_tx_data}, 32'd0);
        chk_val("rst_busy", {31'd0, bus.o_busy}, 32'd0);
        chk_val("rst_done", {31'd0, bus.o_done}, 32'd0);
        rst_n = 1'b1;
        idle_cycles(8);

        // single frame
        send_frame(32'h0000_0004, 32'h8C22_0000, 32'hDEAD_BEEF, -1, 1'b0, -1);
        idle_cycles(4);

        // start during byte 5 must be ignored and not queued
        send_frame(32'h0000_0004, 32'h8C22_0000, 32'hDEAD_BEEF, 4, 1'b0, -1);
        idle_cycles(30);

        // stray ticks in IDLE and in the first LOAD cycle
        bus.i_tx_done_tick = 1'b1;
        @(negedge clk);
        bus.i_tx_done_tick = 1'b0;
        idle_cycles(3);
        send_frame(32'h0000_0004, 32'h8C22_0000, 32'hDEAD_BEEF, -1, 1'b1, -1);
        idle_cycles(4);

        // reset during byte 7 WAIT, then a fresh full frame
        send_frame(32'h1234_5678, 32'h9ABC_DEF0, 32'h0F1E_2D3C, -1, 1'b0, 6);
        idle_cycles(4);
        send_frame(32'hCAFE_F00D, 32'h0123_4567, 32'h89AB_CDEF, -1, 1'b0, -1);
        idle_cycles(10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
